// File: rtl/uart_copi_tx_arbiter.sv
// Round-robin arbiter sharing one uart_copi transmitter between N_REQ byte requesters.
// Optional watchdog on LAUNCH/WAIT_DONE is enabled by defining UART_COPI_ARB_TIMEOUT_EN.
module uart_copi_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_REQ-1:0]     REQ_VALID,
    input  logic [8*N_REQ-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]     REQ_READY,
    input  logic [1:0]           TX_STATE,
    output logic [7:0]           TX_DATA,
    output logic                 TX_START,
    output logic                 BUSY,
    output logic [ID_W-1:0]      GRANT_ID,
    output logic                 TIMEOUT_ERR
);

    localparam int SW = ID_W + 1;

    if (ID_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("uart_copi_tx_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] next_ptr;
    logic            tx_idle;
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic [SW-1:0]   sum;
    logic [7:0]      win_data;

    assign tx_idle  = (TX_STATE == 2'b00) || (TX_STATE == 2'b11);
    assign next_ptr = (GRANT_ID == ID_W'(N_REQ - 1)) ? '0 : GRANT_ID + 1'b1;

    // Search upward from ptr, wrapping past N_REQ-1, first set bit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            sum = {1'b0, ptr} + SW'(off);
            if (sum >= SW'(N_REQ)) begin
                sum = sum - SW'(N_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!found && REQ_VALID[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_data = REQ_DATA[8*i +: 8];
            end
        end
    end

`ifdef UART_COPI_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       leaving;
    logic       abort;

    assign leaving = ((state == LAUNCH) && (TX_STATE == 2'b10)) ||
                     ((state == WAIT_DONE) && tx_idle);
    // A normal exit on the same cycle as expiry takes precedence over the abort.
    assign abort   = (state != IDLE) && !leaving && ((wd_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            ptr       <= '0;
            REQ_READY <= '0;
            TX_DATA   <= '0;
            TX_START  <= 1'b0;
            BUSY      <= 1'b0;
            GRANT_ID  <= '0;
`ifdef UART_COPI_ARB_TIMEOUT_EN
            TIMEOUT_ERR <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            REQ_READY <= '0;
            case (state)
                IDLE: begin
                    if (found && tx_idle) begin
                        TX_DATA        <= win_data;
                        GRANT_ID       <= win;
                        REQ_READY[win] <= 1'b1;
                        TX_START       <= 1'b1;
                        BUSY           <= 1'b1;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (TX_STATE == 2'b10) begin
                        TX_START <= 1'b0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_idle) begin
                        BUSY  <= 1'b0;
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: begin
                    TX_START <= 1'b0;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
`ifdef UART_COPI_ARB_TIMEOUT_EN
            TIMEOUT_ERR <= 1'b0;
            if (state == IDLE || leaving || abort) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end
            if (abort) begin
                TX_START    <= 1'b0;
                TIMEOUT_ERR <= 1'b1;
                BUSY        <= 1'b0;
                ptr         <= next_ptr;
                state       <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_copi_tx_arbiter.sv
// Directed bench for uart_copi_tx_arbiter with a behavioural uart_copi transmitter model.
module tb_uart_copi_tx_arbiter;

    logic        CLK;
    logic        RESET;
    logic [3:0]  REQ_VALID;
    logic [31:0] REQ_DATA;
    logic [3:0]  REQ_READY;
    logic [1:0]  TX_STATE;
    logic [7:0]  TX_DATA;
    logic        TX_START;
    logic        BUSY;
    logic [1:0]  GRANT_ID;
    logic        TIMEOUT_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    uart_copi_tx_arbiter #(
        .N_REQ(4),
        .ID_W(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .REQ_VALID(REQ_VALID),
        .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY),
        .TX_STATE(TX_STATE),
        .TX_DATA(TX_DATA),
        .TX_START(TX_START),
        .BUSY(BUSY),
        .GRANT_ID(GRANT_ID),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Transmitter model: START must be seen on two negedges, then READY, 10 RUN bits, DONE.
    logic [1:0] m_state;
    logic [9:0] m_shift;
    logic [3:0] m_bit;
    logic       m_seen;
    logic       tx_hold;
    logic       ser;
    logic [9:0] frame;
    logic [3:0] fcnt;

    assign TX_STATE = m_state;
    assign ser      = (m_state == 2'b01) ? m_shift[m_bit] : 1'b1;

    always @(negedge CLK) begin
        if (!RESET || tx_hold) begin
            m_state <= 2'b00;
            m_seen  <= 1'b0;
            m_bit   <= 4'd0;
        end else begin
            case (m_state)
                2'b00, 2'b11: begin
                    if (TX_START) begin
                        if (m_seen) begin
                            m_state <= 2'b10;
                            m_shift <= {1'b1, TX_DATA, 1'b0};
                            m_seen  <= 1'b0;
                        end else begin
                            m_seen <= 1'b1;
                        end
                    end else begin
                        m_seen <= 1'b0;
                    end
                end
                2'b10: begin
                    m_state <= 2'b01;
                    m_bit   <= 4'd0;
                end
                default: begin
                    if (m_bit == 4'd9) m_state <= 2'b11;
                    else               m_bit   <= m_bit + 4'd1;
                end
            endcase
        end
    end

    always @(posedge CLK) begin
        if (m_state == 2'b10) begin
            fcnt <= 4'd0;
        end else if (m_state == 2'b01 && fcnt < 4'd10) begin
            frame[fcnt] <= ser;
            fcnt        <= fcnt + 4'd1;
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  id;
        logic [7:0]  exp_byte;
        bit          hold;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_grant(output bit got, output bit busy_before);
        logic last_busy;
        got         = 1'b0;
        busy_before = 1'b0;
        last_busy   = BUSY;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            if (REQ_READY != 4'b0000) begin
                got         = 1'b1;
                busy_before = last_busy;
                break;
            end
            last_busy = BUSY;
        end
    endtask

    task automatic wait_done(output bit ok, output int start_err, output int ready_cnt);
        ok        = 1'b0;
        start_err = 0;
        ready_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            if (TX_START !== (BUSY && (m_state == 2'b00 || m_state == 2'b11))) start_err++;
            if (REQ_READY != 4'b0000) ready_cnt++;
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_model(input logic [1:0] st, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (m_state == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_xfer(input logic [1:0] id, input logic [7:0] b, input bit hold, input string nm);
        bit got;
        bit busy_before;
        bit ok;
        int start_err;
        int ready_cnt;
        logic [3:0] exp_ready;
        exp_ready     = 4'b0000;
        exp_ready[id] = 1'b1;
        wait_grant(got, busy_before);
        check({nm, "_granted"}, 64'(got), 64'd1);
        check({nm, "_ready"}, 64'(REQ_READY), 64'(exp_ready));
        check({nm, "_grant_id"}, 64'(GRANT_ID), 64'(id));
        check({nm, "_tx_data"}, 64'(TX_DATA), 64'(b));
        check({nm, "_start_busy"}, 64'({TX_START, BUSY}), 64'(2'b11));
        check({nm, "_no_overlap"}, 64'(busy_before), 64'd0);
        if (!hold) REQ_VALID = 4'b0000;
        wait_done(ok, start_err, ready_cnt);
        check({nm, "_done"}, 64'(ok), 64'd1);
        check({nm, "_start_hold"}, 64'(start_err), 64'd0);
        check({nm, "_ready_pulse"}, 64'(ready_cnt), 64'd0);
        check({nm, "_frame"}, 64'({fcnt, frame}), 64'({4'd10, 1'b1, b, 1'b0}));
    endtask

    initial begin
        bit got;
        bit busy_before;
        bit ok;
        int start_err;
        int ready_cnt;
        int n;
        int bad;

        RESET     = 1'b0;
        REQ_VALID = 4'b1111;
        REQ_DATA  = 32'h13121110;
        tx_hold   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("reset_outputs",
                  64'({REQ_READY, TX_START, TX_DATA, BUSY, GRANT_ID, TIMEOUT_ERR}), 64'd0);
        end
        RESET = 1'b1;

        vecs[0] = '{4'b1111, 32'h13121110, 2'd0, 8'h10, 1'b1};
        vecs[1] = '{4'b1111, 32'h13121110, 2'd1, 8'h11, 1'b1};
        vecs[2] = '{4'b1111, 32'h13121110, 2'd2, 8'h12, 1'b1};
        vecs[3] = '{4'b1111, 32'h13121110, 2'd3, 8'h13, 1'b1};
        vecs[4] = '{4'b1111, 32'h13121110, 2'd0, 8'h10, 1'b1};
        vecs[5] = '{4'b0100, 32'h13A51110, 2'd2, 8'hA5, 1'b0};
        vecs[6] = '{4'b0011, 32'h13121110, 2'd0, 8'h10, 1'b0};
        vecs[7] = '{4'b1010, 32'h13121110, 2'd1, 8'h11, 1'b0};
        vecs[8] = '{4'b1001, 32'h13121110, 2'd3, 8'h13, 1'b0};

        for (int i = 0; i < 9; i++) begin
            REQ_DATA  = vecs[i].data;
            REQ_VALID = vecs[i].valid;
            run_xfer(vecs[i].id, vecs[i].exp_byte, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Requester 1 arrives while requester 3 is being sent.
        REQ_VALID = 4'b1000;
        wait_grant(got, busy_before);
        check("mid_first_grant", 64'({got, GRANT_ID}), 64'({1'b1, 2'd3}));
        REQ_VALID = 4'b0000;
        wait_model(2'b01, ok);
        check("mid_reach_run", 64'(ok), 64'd1);
        REQ_VALID = 4'b0010;
        wait_done(ok, start_err, ready_cnt);
        check("mid_no_early_grant", 64'({ok, 8'(ready_cnt)}), 64'({1'b1, 8'd0}));
        wait_grant(got, busy_before);
        check("mid_next_grant", 64'({got, REQ_READY, GRANT_ID, TX_DATA}), 64'({1'b1, 4'b0010, 2'd1, 8'h11}));
        REQ_VALID = 4'b0000;
        wait_done(ok, start_err, ready_cnt);
        check("mid_second_done", 64'(ok), 64'd1);

        // Reset while the arbiter waits for DONE.
        REQ_VALID = 4'b0001;
        wait_grant(got, busy_before);
        check("rst_grant", 64'({got, GRANT_ID}), 64'({1'b1, 2'd0}));
        REQ_VALID = 4'b0000;
        wait_model(2'b01, ok);
        check("rst_reach_run", 64'(ok), 64'd1);
        RESET = 1'b0;
        @(posedge CLK); #1;
        check("rst_mid_outputs", 64'({BUSY, TX_START, REQ_READY, GRANT_ID, TX_DATA}), 64'd0);
        @(posedge CLK); #1;
        RESET     = 1'b1;
        REQ_VALID = 4'b1111;
        REQ_DATA  = 32'h13121110;
        run_xfer(2'd0, 8'h10, 1'b0, "post_reset");

        // Transmitter stuck in STBY.
        tx_hold   = 1'b1;
        REQ_VALID = 4'b0100;
        wait_grant(got, busy_before);
        check("stuck_grant", 64'({got, GRANT_ID}), 64'({1'b1, 2'd2}));
        REQ_VALID = 4'b0000;
`ifdef UART_COPI_ARB_TIMEOUT_EN
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            n++;
            if (TIMEOUT_ERR) begin
                got = 1'b1;
                break;
            end
        end
        check("timeout_seen", 64'(got), 64'd1);
        check("timeout_cycles", 64'(n), 64'd16);
        check("timeout_outputs", 64'({TX_START, BUSY}), 64'd0);
        @(posedge CLK); #1;
        check("timeout_pulse_len", 64'({TIMEOUT_ERR, BUSY}), 64'd0);
`else
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK); #1;
            if (!(BUSY && TX_START && !TIMEOUT_ERR)) bad++;
        end
        check("stuck_in_launch", 64'(bad), 64'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
`endif
        tx_hold = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_copi_tx_arbiter.md
# uart_copi_tx_arbiter

Round-robin scheduler that shares one `uart_copi_if` transmitter between N byte requesters. It sits between the requesters and the transmitter, driving INPUT_DATA_REG and START_SEND_DATA and watching STATE. Each byte is launched only when the transmitter is idle, held until the transmitter leaves idle, and tracked through to DONE. Requesters that lose arbitration wait; none is starved.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of GRANT_ID; must equal clog2(N_REQ), minimum 1.
- TIMEOUT_CYCLES, 64: watchdog limit in CLK cycles, 1..255. Used only when UART_COPI_ARB_TIMEOUT_EN is defined.
- Ports:
  - CLK  in  1  clock; all logic is on the posedge.
  - RESET  in  1  reset, synchronous, active-low.
  - REQ_VALID  in  N_REQ  bit i: requester i has a byte pending.
  - REQ_DATA  in  8*N_REQ  byte i sits at [8i+7:8i].
  - REQ_READY  out  N_REQ  one-cycle grant pulse; the byte was latched.
  - TX_STATE  in  2  transmitter STATE: 00 STBY, 10 READY, 01 RUN, 11 DONE.
  - TX_DATA  out  8  drives INPUT_DATA_REG.
  - TX_START  out  1  drives START_SEND_DATA.
  - BUSY  out  1  high in any state other than IDLE.
  - GRANT_ID  out  ID_W  index of the current or last granted requester.
  - TIMEOUT_ERR  out  1  one-cycle pulse when the watchdog aborts a transfer.

## Operation
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, watchdog counter 0.
- The transmitter counts as idle when TX_STATE is 00 or 11.
- IDLE:
  - Condition: any REQ_VALID bit set and transmitter idle.
  - Winner: the first set bit found by searching upward from the pointer, wrapping past N_REQ-1 to 0.
  - Registered actions: TX_DATA ← winner's byte; GRANT_ID ← winner; REQ_READY[winner] = 1 for exactly one cycle; TX_START ← 1; go to LAUNCH.
  - If the transmitter is not idle, valid requests wait.
- LAUNCH:
  - Hold TX_START = 1 and TX_DATA stable.
  - When TX_STATE == 10 is sampled: TX_START ← 0, go to WAIT_DONE.
- WAIT_DONE:
  - TX_STATE == 11 sampled: go to IDLE; pointer ← winner+1 (mod N_REQ).
  - TX_STATE == 00 sampled (transmitter was reset): go to IDLE; pointer still advances; no error flagged.
- REQ_VALID is ignored outside IDLE.
- REQ_VALID may drop before a grant; that request is simply not served.
- The requester must hold REQ_DATA stable while REQ_VALID is high. It may change data, or drop valid, on the edge where it sees REQ_READY.
- TX_DATA is never changed outside the IDLE→LAUNCH transition.
- Reset mid-transfer forces IDLE immediately with all outputs 0. This can truncate the transmitter's START hold; acceptable, because the transmitter shares RESET.

## Timing
- Posedge k, IDLE with a valid request: after edge k, REQ_READY, TX_START, TX_DATA and GRANT_ID are all valid. REQ_READY falls after edge k+1.
- The transmitter consumes START on its own negedge. It needs its delay counter at 0, so READY typically appears 1–3 cycles after TX_START rises.
- TX_START falls on the posedge where TX_STATE == 10 is sampled.
- DONE is sampled about 12 cycles after READY: 10 RUN bit cycles plus the done flag.
- Back-to-back: a new grant can issue on the posedge after DONE is sampled, because 11 counts as idle. Minimum gap between grants is 2 cycles (WAIT_DONE→IDLE, then IDLE→LAUNCH).
- Fairness: with all requesters valid, grants cycle 0,1,…,N_REQ-1,0.

## Configuration
- Macro: UART_COPI_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on every state change and increments each cycle in LAUNCH and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: TX_START ← 0, TIMEOUT_ERR pulses for one cycle, go to IDLE, pointer advances.
  - The aborted byte is not retried.
- Not defined: no counter; TIMEOUT_ERR is tied to 0; LAUNCH and WAIT_DONE wait indefinitely.

## Test plan
- Reset held for 3 cycles with REQ_VALID = 4'b1111:
  - REQ_READY = 0, TX_START = 0, TX_DATA = 0, BUSY = 0 throughout.
  - After release, the first grant goes to requester 0.
- Single requester 2 with 0xA5, transmitter model attached:
  - REQ_READY = 4'b0100 for one cycle; TX_DATA = 0xA5; TX_START high until TX_STATE = 10.
  - SER_DATA carries 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1.
  - BUSY falls after DONE.
- All four valid with bytes 0x10..0x13, held continuously:
  - Grant order is 0,1,2,3,0.
  - Each TX_DATA matches its requester's byte.
  - No REQ_READY pulse overlaps a BUSY transfer.
- Requester 1 asserts valid in the middle of requester 3's transfer:
  - No grant until requester 3 completes.
  - Next grant goes to requester 1 (the pointer wrapped to 0 and finds 1).
- Transmitter held in RESET_STBY and never reaches READY, with the macro defined and TIMEOUT_CYCLES = 16:
  - TIMEOUT_ERR pulses 16 cycles after LAUNCH entry; TX_START = 0; BUSY = 0.
  - Without the macro, the design is still in LAUNCH at 200 cycles.
- RESET asserted while in WAIT_DONE:
  - The next posedge gives BUSY = 0, TX_START = 0, pointer = 0.
  - After release, a new request is granted normally.
